// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive stage, the transmit stage and
// the receive FIFO.
package uart_pkg;

  // Width of one UART character.
  localparam int UART_DATA_WIDTH = 8;

  // Default baud divider.
  localparam int UART_CYCLES_PER_BIT = 217;

  // Default depth of the receive buffer.
  localparam int UART_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream interface around the UART receive FIFO.
// The receive stage writes through the single-cycle strobe pair.
// The consumer drains the FWFT valid/data stream with i_ready.
// The master modport is the producer/consumer side; the slave modport is the FIFO.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  i_rx_valid;
  logic [DATA_WIDTH-1:0] i_rx_byte;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  i_ready;

  modport master (
    output i_rx_valid,
    output i_rx_byte,
    output i_ready,
    input  o_valid,
    input  o_data
  );

  modport slave (
    input  i_rx_valid,
    input  i_rx_byte,
    input  i_ready,
    output o_valid,
    output o_data
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// Dual-port register array for the receive FIFO.
// Writes happen on the rising clock edge. Reads are asynchronous, so the
// head entry can be presented first-word-fall-through.
// The array is not reset.
module fifo_mem_dp #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Store one incoming byte per enabled edge; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO.
// It sits between the UART receiver and a slower consumer.
// Configuration macro: UART_RX_FIFO_OVERWRITE_EN.
//   When defined, a byte arriving at a full FIFO replaces the oldest entry.
//   When undefined, that byte is dropped.
//   In both cases the sticky overflow flag is set.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = UART_RX_FIFO_DEPTH,
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  uart_rx_fifo_if.slave            bus,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow,
  input  logic                     i_clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         wrPtr_q, wrPtr_d;
  logic [PW-1:0]         rdPtr_q, rdPtr_d;
  logic                  overflow_q, overflow_d;
  logic                  fullNow;
  logic                  emptyNow;
  logic                  pop;
  logic                  push;
  logic                  overflowEvent;
  logic                  memWe;
  logic [DATA_WIDTH-1:0] rdData;

  // The extra pointer MSB is a wrap bit, which tells a full FIFO from an empty one.
  assign emptyNow = (wrPtr_q == rdPtr_q);
  assign fullNow  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) &&
                    (wrPtr_q[AW] != rdPtr_q[AW]);

  assign pop           = !emptyNow && bus.i_ready;
  assign push          = bus.i_rx_valid && (!fullNow || pop);
  assign overflowEvent = bus.i_rx_valid && fullNow && !pop;

  // Compute the next pointer and overflow state from the push/pop/overflow events.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    overflow_d = overflow_q;
    memWe      = push;
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
`ifdef UART_RX_FIFO_OVERWRITE_EN
    if (overflowEvent) begin
      memWe   = 1'b1;
      wrPtr_d = wrPtr_q + 1'b1;
      rdPtr_d = rdPtr_q + 1'b1;
    end
`endif
    if (i_clear_overflow) begin
      overflow_d = 1'b0;
    end
    if (overflowEvent) begin
      overflow_d = 1'b1;
    end
  end

  // Register the pointers and the sticky flag; reset overrides any traffic.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      overflow_q <= overflow_d;
    end
  end

  fifo_mem_dp #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (memWe),
    .i_waddr (wrPtr_q[AW-1:0]),
    .i_wdata (bus.i_rx_byte),
    .i_raddr (rdPtr_q[AW-1:0]),
    .o_rdata (rdData)
  );

  assign bus.o_valid = !emptyNow;
  assign bus.o_data  = rdData;
  assign o_count     = wrPtr_q - rdPtr_q;
  assign o_full      = fullNow;
  assign o_empty     = emptyNow;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo using a scoreboard.
// Stimulus pushes the bytes it expects to read back into a queue.
// A negedge monitor pops that queue on every accepted output byte and compares.
// Also honours UART_RX_FIFO_OVERWRITE_EN for the overwrite variant.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic         clk = 1'b0;
  logic         rstN;
  logic [4:0]   count;
  logic         full;
  logic         empty;
  logic         overflow;
  logic         clearOverflow;

  int           checkCount = 0;
  int           errorCount = 0;
  logic [DW-1:0] expQ [$];

  uart_rx_fifo_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rstN),
    .bus              (bus),
    .o_count          (count),
    .o_full           (full),
    .o_empty          (empty),
    .o_overflow       (overflow),
    .i_clear_overflow (clearOverflow)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Scoreboard monitor: a byte accepted this cycle must match the oldest expected byte.
  always @(negedge clk) begin
    if (rstN && bus.o_valid && bus.i_ready) begin
      checkCount++;
      if (expQ.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL popData: got 0x%02h, scoreboard empty", bus.o_data);
      end else begin
        logic [DW-1:0] exp;
        exp = expQ.pop_front();
        if (bus.o_data !== exp) begin
          errorCount++;
          $display("[TB] FAIL popData: got 0x%02h, expected 0x%02h", bus.o_data, exp);
        end
      end
    end
  end

  // Drive one cycle of inputs and update the reference queue, then step past the edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [DW-1:0] b,
                               input logic rdy, input logic clr);
    bit popM;
    bit fullM;
    rstN              = rst;
    bus.i_rx_valid    = v;
    bus.i_rx_byte     = b;
    bus.i_ready       = rdy;
    clearOverflow     = clr;
    if (!rst) begin
      expQ.delete();
    end else begin
      popM  = rdy && (expQ.size() > 0);
      fullM = (expQ.size() == DEPTH);
      if (v) begin
        if (!fullM || popM) begin
          expQ.push_back(b);
        end else begin
`ifdef UART_RX_FIFO_OVERWRITE_EN
          void'(expQ.pop_front());
          expQ.push_back(b);
`endif
        end
      end
    end
    @(posedge clk);
    #1;
    rstN           = 1'b1;
    bus.i_rx_valid = 1'b0;
    bus.i_ready    = 1'b0;
    clearOverflow  = 1'b0;
  endtask

  // Compare one observed value against a hand-computed expectation.
  task automatic compareVal(input string name, input int act, input int exp);
    checkCount++;
    if (act != exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Check the status outputs right after an edge.
  task automatic checkOutput(input string name, input int expCount, input bit expOvf);
    compareVal({name, ".count"}, int'(count), expCount);
    compareVal({name, ".valid"}, int'(bus.o_valid), int'(expCount != 0));
    compareVal({name, ".empty"}, int'(empty), int'(expCount == 0));
    compareVal({name, ".full"}, int'(full), int'(expCount == DEPTH));
    compareVal({name, ".overflow"}, int'(overflow), int'(expOvf));
  endtask

  initial begin
    rstN           = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_byte  = '0;
    bus.i_ready    = 1'b0;
    clearOverflow  = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("reset", 0, 1'b0);

    // Single byte: visible one cycle after the push, then pop it.
    applyStimulus(1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
    checkOutput("push41", 1, 1'b0);
    compareVal("head41", int'(bus.o_data), 'h41);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("pop41", 0, 1'b0);

    // Fill to DEPTH.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
    end
    checkOutput("fill", 16, 1'b0);
    compareVal("fillHead", int'(bus.o_data), 'h00);

    // Push into a full FIFO with no pop.
    applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("overflowAA", 16, 1'b1);
`ifdef UART_RX_FIFO_OVERWRITE_EN
    compareVal("overflowHead", int'(bus.o_data), 'h01);
`else
    compareVal("overflowHead", int'(bus.o_data), 'h00);
`endif

    // Clear alone, then clear together with a fresh overflow, then clear again.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clearAlone", 16, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hBB, 1'b0, 1'b1);
    checkOutput("clearVsSet", 16, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clearAgain", 16, 1'b0);

    // Full FIFO with simultaneous push and pop: no overflow, count held.
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("pushPopFull", 16, 1'b0);

    // Drain everything; the monitor checks order and contents.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("drained", 0, 1'b0);

    // Partial fill, then reset mid-stream with a byte arriving.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    end
    checkOutput("five", 5, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
    checkOutput("midReset", 0, 1'b0);

    // First byte after reset is the first one read.
    applyStimulus(1'b1, 1'b1, 8'h7E, 1'b0, 1'b0);
    checkOutput("push7E", 1, 1'b0);
    compareVal("head7E", int'(bus.o_data), 'h7E);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("pop7E", 0, 1'b0);

    // Every expected byte must have been consumed.
    compareVal("scoreboardLeft", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Buffers bytes from the UART receiver so a slower consumer can drain them with a ready/valid handshake.
- Input: single-cycle valid strobe plus byte, straight from the UART receive stage.
- Output: first-word-fall-through (FWFT) ready/valid stream to the downstream command/display logic.
- Flags an overflow when a byte arrives while the FIFO is full.

Parameters:
- DEPTH, 16, number of byte entries; power of two, >= 2.
- DATA_WIDTH, 8, bits per entry; matches the UART byte width.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_rx_valid  input  1  one-cycle strobe: i_rx_byte holds a received byte.
- i_rx_byte  input  DATA_WIDTH  received byte; sampled only when i_rx_valid=1.
- o_valid  output  1  head entry available (FIFO not empty).
- o_data  output  DATA_WIDTH  head entry; meaningful only when o_valid=1.
- i_ready  input  1  consumer accepts the head entry this cycle.
- o_count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- o_full  output  1  o_count == DEPTH.
- o_empty  output  1  o_count == 0.
- o_overflow  output  1  sticky: at least one byte has been dropped or overwritten.
- i_clear_overflow  input  1  clears o_overflow.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Resulting outputs: o_valid=0, o_empty=1, o_full=0, o_count=0, o_overflow=0.
  - Memory array is not reset. Reset overrides all other inputs, including mid-stream.
- Pointers: $clog2(DEPTH)+1 bits. The low bits index memory; the MSB is a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
  - o_count = wr_ptr - rd_ptr, modulo 2^(ptr width).
- Pop: pop = o_valid & i_ready. Advances rd_ptr at the edge.
  - i_ready while o_valid=0 has no effect.
- Push: push = i_rx_valid & (~full | pop). Writes mem[wr_ptr] and advances wr_ptr at the edge.
- Latency: a byte pushed into an empty FIFO at edge N appears on o_valid/o_data after edge N (one cycle). There is no bypass.
- FWFT: o_data = mem[rd_ptr[low bits]]. Combinational read of registered storage is permitted.
- Simultaneous push and pop:
  - Non-empty FIFO: both take effect; count is unchanged.
  - Full FIFO: both take effect; no overflow.
  - Empty FIFO: pop is impossible (o_valid=0); push only.
- Overflow: i_rx_valid & full & ~pop drops the byte (see Optional Feature). overflow is set at that edge.
- Overflow clear: i_clear_overflow=1 clears overflow at the edge. If a new overflow occurs in the same cycle, set wins.
- o_full, o_empty and o_count are derived from the registered pointers. They reflect the edge just taken, with no extra delay.

Optional Feature:
- Macro: UART_RX_FIFO_OVERWRITE_EN.
- Defined: push while full with no pop overwrites the oldest entry.
  - Write mem[wr_ptr]; advance both wr_ptr and rd_ptr.
  - count stays DEPTH; overflow is still set.
  - Head becomes the former second-oldest byte.
- Undefined: the incoming byte is dropped; pointers are unchanged.

Decomposition:
- Shared package/include uart_pkg:
  - UART_DATA_WIDTH = 8.
  - Default UART_CYCLES_PER_BIT = 217.
  - Used by both UART stages and this FIFO.
- One sub-module: fifo_mem_dp.
  - DEPTH x DATA_WIDTH register array.
  - Synchronous write port (we, waddr, wdata); asynchronous read port (raddr, rdata).
  - Pointer and flag logic stay in uart_rx_fifo.

Test Plan:
- Reset, then push 0x41 with i_ready=0 -> next cycle: o_valid=1, o_data=0x41, o_count=1, o_empty=0.
- Push 0x00..0x0F (DEPTH=16) with i_ready=0 -> o_full=1, o_count=16. Then pop 16 with i_ready=1 -> data 0x00..0x0F in order; o_empty=1 at the end.
- Full FIFO, push 0xAA with i_ready=0:
  - Macro undefined -> o_overflow=1, head=0x00, count=16.
  - Macro defined -> o_overflow=1, head=0x01, last-read entry=0xAA.
- Full FIFO, push 0x55 with i_ready=1 in the same cycle -> 0x00 popped, count=16, o_overflow=0, 0x55 read last.
- Overflow set, then assert i_clear_overflow alone -> o_overflow=0 next cycle. Assert clear together with a new overflow -> o_overflow stays 1.
- Push 5 bytes, then pull i_rst_n low for one cycle while i_rx_valid=1 -> o_count=0, o_valid=0, o_overflow=0. Next push 0x7E -> it is read first.
